// File: rtl/cfa_pkg.sv
// Shared constants for the CFA demosaicing pipeline (window stage and gradients_2).
package cfa_pkg;

    localparam int unsigned CFA_PIX_W = 12;
    localparam int unsigned CFA_WIN_R = 2;
    localparam int unsigned CFA_WIN_N = 2 * CFA_WIN_R + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } cfa_state_e;

endpackage

// File: rtl/cfa_window_5x5_if.sv
// Raster pixel stream into the window stage: one pixel per valid cycle, sof marks (0,0).
interface cfa_window_5x5_if
    import cfa_pkg::*;
#(
    parameter int unsigned PIX_W = CFA_PIX_W
);

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             sof;

    modport master (output pix_in, output pix_valid, output sof);
    modport slave  (input  pix_in, input  pix_valid, input  sof);

endinterface

// File: rtl/cfa_line_buffer.sv
// One line of pixel storage: combinational read, write on the clock edge (read-before-write).
module cfa_line_buffer #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [PIX_W-1:0]  i_wdata,
    output logic [PIX_W-1:0]  o_rdata
);

    // Contents are deliberately not reset; stale lines are masked by the start gating upstream.
    logic [PIX_W-1:0] r_mem [DEPTH];

    // Synchronous write at the current column.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/cfa_window_5x5.sv
// Raster-to-window stage: builds a sliding 5x5 Bayer neighbourhood and emits interior windows.
module cfa_window_5x5
    import cfa_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = CFA_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    cfa_window_5x5_if.slave  pix_if,
    output logic             start,
    output logic [PIX_W-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
    output logic [PIX_W-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
    output logic [PIX_W-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
    output logic [PIX_W-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
    output logic [PIX_W-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
    output logic             frame_done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned N_LB  = CFA_WIN_N - 1;

    cfa_state_e       r_state, w_state_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt, w_col_cur;
    logic [ROW_W-1:0] r_row, w_row_nxt, w_row_cur;
    logic             r_start, w_start_nxt;
    logic             r_frame_done, w_fd_nxt;
    logic             w_sof_hit, w_accept, w_last;

    logic [PIX_W-1:0] w_pix;
    logic             w_pix_valid;
    logic             w_sof;

    logic [PIX_W-1:0] w_lb_rd  [N_LB];
    logic [PIX_W-1:0] w_new_col[CFA_WIN_N];
    logic [PIX_W-1:0] r_win    [CFA_WIN_N][CFA_WIN_N];

    assign w_pix       = pix_if.pix_in;
    assign w_pix_valid = pix_if.pix_valid;
    assign w_sof       = pix_if.sof;

    // Next-state, counter and output-pulse decode; sof restarts the frame from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_start_nxt = 1'b0;
        w_fd_nxt    = 1'b0;

        w_sof_hit = w_pix_valid & w_sof;
        w_accept  = w_sof_hit | (w_pix_valid & (r_state == ST_ACTIVE));
        w_row_cur = w_sof_hit ? '0 : r_row;
        w_col_cur = w_sof_hit ? '0 : r_col;
        w_last    = (w_row_cur == ROW_W'(IMG_H - 1)) && (w_col_cur == COL_W'(IMG_W - 1));

        if (w_accept) begin
            w_start_nxt = (w_row_cur >= ROW_W'(N_LB)) && (w_col_cur >= COL_W'(N_LB));
            w_fd_nxt    = w_last;
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
            end else begin
                w_state_nxt = ST_ACTIVE;
                if (w_col_cur == COL_W'(IMG_W - 1)) begin
                    w_col_nxt = '0;
                    w_row_nxt = w_row_cur + ROW_W'(1);
                end else begin
                    w_col_nxt = w_col_cur + COL_W'(1);
                    w_row_nxt = w_row_cur;
                end
            end
        end
    end

    // State, raster position and output pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_start      <= w_start_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    // Line-buffer chain: lb0 holds row r-1, lb3 holds row r-4; each pixel pushes the column down.
    for (genvar k = 0; k < N_LB; k++) begin : g_lb
        logic [PIX_W-1:0] w_wdata;
        if (k == 0) begin : g_head
            assign w_wdata = w_pix;
        end else begin : g_tail
            assign w_wdata = w_lb_rd[k-1];
        end
        cfa_line_buffer #(
            .DEPTH  (IMG_W),
            .PIX_W  (PIX_W),
            .ADDR_W (COL_W)
        ) u_lb (
            .clk     (clk),
            .i_we    (w_accept),
            .i_addr  (w_col_cur),
            .i_wdata (w_wdata),
            .o_rdata (w_lb_rd[k])
        );
    end

    // Incoming column, oldest row first: {lb3, lb2, lb1, lb0, pix_in}.
    always_comb begin
        for (int i = 0; i < int'(N_LB); i++) begin
            w_new_col[i] = w_lb_rd[N_LB-1-i];
        end
        w_new_col[CFA_WIN_N-1] = w_pix;
    end

    // 5x5 window: shift one column toward m2 on every accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(CFA_WIN_N); i++) begin
                for (int j = 0; j < int'(CFA_WIN_N); j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < int'(CFA_WIN_N); i++) begin
                for (int j = 0; j < int'(CFA_WIN_N) - 1; j++) begin
                    r_win[i][j] <= r_win[i][j+1];
                end
                r_win[i][CFA_WIN_N-1] <= w_new_col[i];
            end
        end
    end

    assign start      = r_start;
    assign frame_done = r_frame_done;

    assign p_m2_m2 = r_win[0][0];
    assign p_m2_m1 = r_win[0][1];
    assign p_m2_p0 = r_win[0][2];
    assign p_m2_p1 = r_win[0][3];
    assign p_m2_p2 = r_win[0][4];
    assign p_m1_m2 = r_win[1][0];
    assign p_m1_m1 = r_win[1][1];
    assign p_m1_p0 = r_win[1][2];
    assign p_m1_p1 = r_win[1][3];
    assign p_m1_p2 = r_win[1][4];
    assign p_p0_m2 = r_win[2][0];
    assign p_p0_m1 = r_win[2][1];
    assign p_p0_p0 = r_win[2][2];
    assign p_p0_p1 = r_win[2][3];
    assign p_p0_p2 = r_win[2][4];
    assign p_p1_m2 = r_win[3][0];
    assign p_p1_m1 = r_win[3][1];
    assign p_p1_p0 = r_win[3][2];
    assign p_p1_p1 = r_win[3][3];
    assign p_p1_p2 = r_win[3][4];
    assign p_p2_m2 = r_win[4][0];
    assign p_p2_m1 = r_win[4][1];
    assign p_p2_p0 = r_win[4][2];
    assign p_p2_p1 = r_win[4][3];
    assign p_p2_p2 = r_win[4][4];

endmodule

// File: tb/tb_cfa_window_5x5.sv
// Bench for cfa_window_5x5: directed ramp frames plus random frames against a frame-image model.
module tb_cfa_window_5x5;

    localparam int IW = 8;
    localparam int IH = 6;
    localparam int PW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cfa_window_5x5_if #(.PIX_W(PW)) pif ();

    logic          start, frame_done;
    logic [PW-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2;
    logic [PW-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2;
    logic [PW-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2;
    logic [PW-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2;
    logic [PW-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2;
    logic [PW-1:0] obs [25];

    cfa_window_5x5 #(.IMG_W(IW), .IMG_H(IH), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .pix_if(pif), .start(start),
        .p_m2_m2(p_m2_m2), .p_m2_m1(p_m2_m1), .p_m2_p0(p_m2_p0), .p_m2_p1(p_m2_p1), .p_m2_p2(p_m2_p2),
        .p_m1_m2(p_m1_m2), .p_m1_m1(p_m1_m1), .p_m1_p0(p_m1_p0), .p_m1_p1(p_m1_p1), .p_m1_p2(p_m1_p2),
        .p_p0_m2(p_p0_m2), .p_p0_m1(p_p0_m1), .p_p0_p0(p_p0_p0), .p_p0_p1(p_p0_p1), .p_p0_p2(p_p0_p2),
        .p_p1_m2(p_p1_m2), .p_p1_m1(p_p1_m1), .p_p1_p0(p_p1_p0), .p_p1_p1(p_p1_p1), .p_p1_p2(p_p1_p2),
        .p_p2_m2(p_p2_m2), .p_p2_m1(p_p2_m1), .p_p2_p0(p_p2_p0), .p_p2_p1(p_p2_p1), .p_p2_p2(p_p2_p2),
        .frame_done(frame_done)
    );

    always_comb begin
        obs[0]  = p_m2_m2; obs[1]  = p_m2_m1; obs[2]  = p_m2_p0; obs[3]  = p_m2_p1; obs[4]  = p_m2_p2;
        obs[5]  = p_m1_m2; obs[6]  = p_m1_m1; obs[7]  = p_m1_p0; obs[8]  = p_m1_p1; obs[9]  = p_m1_p2;
        obs[10] = p_p0_m2; obs[11] = p_p0_m1; obs[12] = p_p0_p0; obs[13] = p_p0_p1; obs[14] = p_p0_p2;
        obs[15] = p_p1_m2; obs[16] = p_p1_m1; obs[17] = p_p1_p0; obs[18] = p_p1_p1; obs[19] = p_p1_p2;
        obs[20] = p_p2_m2; obs[21] = p_p2_m1; obs[22] = p_p2_p0; obs[23] = p_p2_p1; obs[24] = p_p2_p2;
    end

    // Reference model: the current frame as an image plus the raster position.
    int            img [IH][IW];
    bit            m_active;
    int            m_row, m_col;
    logic [PW-1:0] exp_win [25];
    logic [PW-1:0] snap [25];

    int checks = 0;
    int errors = 0;

    int   n_start, first_m2m2, first_p0p0, first_p2p2, last_p2p2, last_fd;
    bit   chk_b2b;
    logic prev_start;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic clr_stats();
        n_start = 0; first_m2m2 = -1; first_p0p0 = -1; first_p2p2 = -1;
        last_p2p2 = -1; last_fd = -1;
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_row = 0; m_col = 0;
    endtask

    // Drive one cycle, advance the model, then compare outputs after the edge.
    task automatic step(input int pix, input bit valid, input bit s);
        bit acc, exp_s, exp_fd;
        int r, c;
        pif.pix_in    = PW'(pix);
        pif.pix_valid = valid;
        pif.sof       = s;
        @(posedge clk);
        #1;
        acc    = valid && (s || m_active);
        exp_s  = 1'b0;
        exp_fd = 1'b0;
        if (acc) begin
            if (s) begin m_row = 0; m_col = 0; end
            r = m_row; c = m_col;
            img[r][c] = pix;
            if (r >= 4 && c >= 4) begin
                exp_s = 1'b1;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        exp_win[i*5+j] = PW'(img[r-4+i][c-4+j]);
            end
            exp_fd = (r == IH-1) && (c == IW-1);
            if (exp_fd) begin
                model_reset();
            end else begin
                m_active = 1'b1;
                m_col++;
                if (m_col == IW) begin m_col = 0; m_row++; end
            end
        end
        check("start", 32'(start), 32'(exp_s));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        if (exp_s)
            for (int k = 0; k < 25; k++)
                check($sformatf("win[%0d] r%0d c%0d", k, r, c), 32'(obs[k]), 32'(exp_win[k]));
        if (chk_b2b)
            check("start_back_to_back", 32'(prev_start & start), 32'd0);
        prev_start = start;
        if (start === 1'b1) begin
            n_start++;
            if (n_start == 1) begin
                first_m2m2 = int'(obs[0]); first_p0p0 = int'(obs[12]); first_p2p2 = int'(obs[24]);
            end
            last_p2p2 = int'(obs[24]);
            last_fd   = int'(frame_done);
        end
    endtask

    // mode_pix: 0 ramp, 1 random. mode_valid: 0 continuous, 1 toggle 1/0, 2 random gaps.
    task automatic run_frame(input int mode_pix, input int mode_valid);
        int pix, gaps;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                pix = (mode_pix == 0) ? (r * 16 + c) : int'($urandom_range(0, 4095));
                step(pix, 1'b1, (r == 0) && (c == 0));
                gaps = (mode_valid == 1) ? 1 : (mode_valid == 2) ? int'($urandom_range(0, 2)) : 0;
                for (int g = 0; g < gaps; g++)
                    step(int'($urandom_range(0, 4095)), 1'b0, 1'($urandom));
            end
        end
    endtask

    task automatic ramp_checks(input string tag);
        check({tag, " n_start"}, n_start, 8);
        check({tag, " first p_m2_m2"}, first_m2m2, 0);
        check({tag, " first p_p0_p0"}, first_p0p0, 34);
        check({tag, " first p_p2_p2"}, first_p2p2, 68);
        check({tag, " last p_p2_p2"}, last_p2p2, 87);
        check({tag, " last frame_done"}, last_fd, 1);
    endtask

    initial begin
        pif.pix_in = '0; pif.pix_valid = 1'b0; pif.sof = 1'b0;
        chk_b2b = 1'b0; prev_start = 1'b0;
        model_reset();
        clr_stats();

        // Reset held with random inputs.
        for (int n = 0; n < 5; n++) begin
            pif.pix_in = PW'($urandom); pif.pix_valid = 1'($urandom); pif.sof = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst start", 32'(start), 32'd0);
            check("rst frame_done", 32'(frame_done), 32'd0);
            for (int k = 0; k < 25; k++) check($sformatf("rst win[%0d]", k), 32'(obs[k]), 32'd0);
        end
        rst = 1'b1;

        // Pixels without sof are dropped in idle.
        step(5, 1'b1, 1'b0);
        step(9, 1'b1, 1'b0);
        step(3, 1'b0, 1'b1);

        // Clean ramp, continuous valid.
        clr_stats();
        run_frame(0, 0);
        ramp_checks("ramp");

        // Ramp with valid toggling.
        clr_stats();
        chk_b2b = 1'b1;
        run_frame(0, 1);
        chk_b2b = 1'b0;
        ramp_checks("toggle");

        // Abort at (3,5), then restart the ramp.
        clr_stats();
        for (int idx = 0; idx < 3 * IW + 5; idx++)
            step((idx / IW) * 16 + (idx % IW), 1'b1, idx == 0);
        check("abort no start yet", n_start, 0);
        run_frame(0, 0);
        ramp_checks("abort");

        // Extra pixels after frame end: no output activity, window frozen.
        for (int k = 0; k < 25; k++) snap[k] = obs[k];
        clr_stats();
        for (int n = 0; n < 10; n++) begin
            step(int'($urandom_range(0, 4095)), 1'b1, 1'b0);
            for (int k = 0; k < 25; k++)
                check($sformatf("eof hold win[%0d]", k), 32'(obs[k]), 32'(snap[k]));
        end
        check("eof n_start", n_start, 0);

        // Async reset at ramp pixel (5,2), checked before the next edge.
        for (int idx = 0; idx <= 5 * IW + 2; idx++)
            step((idx / IW) * 16 + (idx % IW), 1'b1, idx == 0);
        check("pre-reset p_p2_p2", 32'(p_p2_p2), 32'd82);
        rst = 1'b0;
        #1;
        check("async start", 32'(start), 32'd0);
        check("async frame_done", 32'(frame_done), 32'd0);
        for (int k = 0; k < 25; k++) check($sformatf("async win[%0d]", k), 32'(obs[k]), 32'd0);
        model_reset();
        #1;
        rst = 1'b1;
        clr_stats();
        run_frame(0, 0);
        ramp_checks("post-reset");

        // Random pixel frames with random valid gaps.
        for (int f = 0; f < 3; f++) begin
            clr_stats();
            run_frame(1, 2);
            check($sformatf("random frame %0d n_start", f), n_start, 8);
            check($sformatf("random frame %0d last frame_done", f), last_fd, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfa_window_5x5.md
# cfa_window_5x5

Raster-to-window stage for the CFA demosaicing pipeline. It accepts a Bayer pixel stream one pixel per valid cycle and builds a sliding 5x5 neighbourhood from four line buffers and a 5x5 register array. For every fully interior centre pixel it presents the 25 window pixels, with a one-cycle `start` pulse, to the directly downstream `gradients_2` stage. Border centres (two rows or columns from any edge) are never emitted.

## Interface
- `IMG_W`, default 640: pixels per line; minimum 5.
- `IMG_H`, default 480: lines per frame; minimum 5.
- `PIX_W`, default 12: pixel width.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `pix_in`, in, PIX_W: raster pixel.
- `pix_valid`, in, 1: `pix_in` is accepted on this edge.
- `sof`, in, 1: qualified by `pix_valid`; marks pixel (row 0, col 0).
- `start`, out, 1: one-cycle pulse; window outputs are valid this cycle.
- `p_m2_m2` … `p_p2_p2`, out, PIX_W each (25 ports): window pixel at (row offset, col offset). `m2` is the oldest row/col and `p2` is the newest. `p_p2_p2` is the most recently accepted pixel.
- `frame_done`, out, 1: one-cycle pulse coincident with the last `start` of a frame.

## Operation
- States: IDLE and ACTIVE.
  - IDLE → ACTIVE on `pix_valid & sof`; that pixel is (0,0).
  - ACTIVE → IDLE after accepting pixel (IMG_H-1, IMG_W-1).
  - `pix_valid & sof` in ACTIVE restarts the frame at (0,0) (abort). This takes priority over normal increment.
  - `pix_valid & ~sof` in IDLE: pixel dropped, no state change.
- Counters `col` (0..IMG_W-1, wraps and increments `row`) and `row` (0..IMG_H-1) have width `$clog2` of their bound. They advance only on accepted pixels.
- On each accepted pixel at (row, col):
  - Read the four line buffers at address `col` to get the column {r-4, r-3, r-2, r-1}.
  - Form the new column {lb3, lb2, lb1, lb0, pix_in}.
  - Shift the 5x5 array one column toward `m2`. The new column enters at `p2`; `p_m2_p2` receives r-4 and `p_p2_p2` receives `pix_in`.
  - Write back the chain at address `col`: lb3←lb2, lb2←lb1, lb1←lb0, lb0←pix_in.
- `start` is registered and set when the accepted pixel has row ≥ 4 and col ≥ 4. The emitted centre is (row-2, col-2).
- Output count per frame is exactly (IMG_H-4)×(IMG_W-4).
- `frame_done` is set together with `start` for pixel (IMG_H-1, IMG_W-1).
- `pix_valid` low: no counter, buffer, or window change; `start` and `frame_done` are 0.
- Line-buffer contents are never reset. Stale data is harmless because `start` is gated until row 4 of the current frame.
- No arithmetic is performed on pixel data; values pass bit-exact.

## Timing
- Latency: window and `start` are visible the cycle after the edge that accepts the completing pixel (1 cycle).
- Window registers hold their value until the next accepted pixel. Downstream may sample any time `start` is high.
- No backpressure. Downstream must accept one window per cycle at a 100% input rate.
- Reset (rst=0), asynchronous and immediate:
  - All 25 window outputs, `start`, and `frame_done` go to 0.
  - State goes to IDLE; `row` and `col` go to 0.
  - Reset mid-frame discards the frame; the next frame requires `sof`.
- Line-buffer read is combinational (async-read RAM or registers). Read and write to the same address share one edge, with read-before-write semantics.

## Structure
- Shared package `cfa_pkg`: PIX_W default, window radius constant (2), and window size constant (5). `gradients_2` reuses these.
- Sub-module `cfa_line_buffer`: one IMG_W×PIX_W line memory with async read and synchronous write. It is instantiated four times.
- The top level holds the FSM, counters, the 5x5 register array, and output flattening.

## Test plan
- Reset: hold `rst`=0 with random inputs. Required response: all outputs 0 and `start`=0. After release, a pixel without `sof` produces no `start`.
- Ramp frame, IMG_W=8, IMG_H=6, pix=row×16+col, continuous `pix_valid`:
  - The first `start` occurs one cycle after pixel 36 (4,4), with `p_m2_m2`=0, `p_p0_p0`=34, and `p_p2_p2`=68.
  - Exactly 8 `start` pulses occur.
  - The last has `p_p2_p2`=87 and `frame_done`=1.
- Same ramp with `pix_valid` toggling 1,0: the same 8 windows, in the same order, with identical values. `start` is never high on two consecutive cycles.
- Abort: assert `sof` again at pixel (3,5) with the ramp restarting. No `start` occurs until new-frame pixel (4,4). The first window then matches the clean-ramp first window.
- End of frame: feed 10 extra pixels without `sof` after a complete frame. Required response: no `start`, no `frame_done`, and window outputs unchanged.
- Async reset asserted at ramp pixel (5,2): outputs go to 0 before the next clock edge. A following clean frame reproduces the clean-ramp results.
